wb_initiator: RTL
=================

WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 Parameter AW, default 30: Wishbone word-address width.
REQ-002 Parameter TIMEOUT_W, default 10: timeout counter width; abort after 2^TIMEOUT_W-1 cycles.
REQ-003 i_clk  in  1  sole clock; all logic on rising edge.
REQ-004 i_reset_n  in  1  reset; synchronous, active-low.
REQ-005 i_cmd_stb  in  1  command request.
REQ-006 i_cmd_we  in  1  1 = write, 0 = read.
REQ-007 i_cmd_addr  in  AW  word address.
REQ-008 i_cmd_data  in  32  write data.
REQ-009 i_cmd_sel  in  4  byte selects.
REQ-010 o_cmd_busy  out  1  command port not ready.
REQ-011 o_rsp_stb  out  1  one-cycle response strobe.
REQ-012 o_rsp_err  out  1  bus error or timeout, valid with o_rsp_stb.
REQ-013 o_rsp_data  out  32  read data, valid with o_rsp_stb.
REQ-014 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  pipelined Wishbone initiator controls.
REQ-015 o_wb_addr  out  AW; o_wb_data  out  32; o_wb_sel  out  4  request fields.
REQ-016 i_wb_stall, i_wb_ack, i_wb_err  in  1 each; i_wb_data  in  32  responder returns.

Function
REQ-017 FSM states SHALL be IDLE, REQ (stb high), WAIT (stb low, cyc high).
REQ-018 Command accepted when i_cmd_stb && !o_cmd_busy in IDLE; fields registered to o_wb_*; next cycle o_wb_cyc=o_wb_stb=1, state REQ.
REQ-019 o_cmd_busy SHALL equal (state != IDLE).
REQ-020 In REQ, o_wb_stb SHALL drop the cycle after a cycle with !i_wb_stall; state -> WAIT.
REQ-021 o_wb_addr/data/sel/we SHALL hold stable while o_wb_stb is high.
REQ-022 i_wb_ack or i_wb_err while o_wb_cyc (REQ or WAIT) SHALL complete: next cycle o_wb_cyc=o_wb_stb=0, o_rsp_stb=1, state IDLE.
REQ-023 On read ack, o_rsp_data = i_wb_data captured that edge; on write ack o_rsp_data=0.
REQ-024 i_wb_err SHALL set o_rsp_err=1, o_rsp_data=0; ack and err together: err wins.
REQ-025 New command accepted in the same cycle o_rsp_stb is high (back-to-back, 1 idle-bus cycle minimum).
REQ-026 i_wb_ack/i_wb_err while !o_wb_cyc SHALL be ignored.
REQ-027 Minimum latency accept -> o_rsp_stb: 3 cycles (zero stall, ack one cycle after stb accepted).

Reset
REQ-028 On !i_reset_n at a clock edge: state IDLE, o_wb_cyc=o_wb_stb=0, o_rsp_stb=0, o_rsp_err=0, o_rsp_data=0, timeout counter 0.
REQ-029 Reset mid-transaction SHALL drop cyc/stb next edge and SHALL NOT emit a response.
REQ-030 o_wb_addr/data/sel/we need no reset value.

Configuration
REQ-031 Macro WB_INITIATOR_TIMEOUT_EN defined: counter clears on accept, increments each cycle o_wb_cyc is high; at 2^TIMEOUT_W-1 with no ack/err, abort as REQ-022 with o_rsp_err=1, o_rsp_data=0.
REQ-032 Macro undefined: no counter; initiator waits indefinitely for ack/err.

Structure
REQ-033 Package wb_initiator_pkg SHALL hold the state enum typedef and the default AW/TIMEOUT_W constants.
REQ-034 Timeout counter SHALL be sub-module wb_timeout (clear, enable, expired), instantiated only under WB_INITIATOR_TIMEOUT_EN.

Verification
REQ-035 Read 0x0000123, no stall, ack+data 0xDEADBEEF one cycle after stb: o_rsp_stb 3 cycles after accept, o_rsp_data=0xDEADBEEF, o_rsp_err=0.
REQ-036 Write 0xA5A5A5A5 sel 0x3, stall 4 cycles: o_wb_stb high exactly 5 cycles, addr/data/sel constant; response err=0, data=0.
REQ-037 Ack and err same cycle on read: o_rsp_err=1, o_rsp_data=0, cyc drops next edge.
REQ-038 Timeout enabled, TIMEOUT_W=4, no ack: o_rsp_stb with err=1 after 15 cycles of cyc; stray ack afterwards ignored.
REQ-039 i_reset_n low during WAIT: cyc/stb 0 next edge, no o_rsp_stb, next command proceeds normally.
REQ-040 Command held on i_cmd_stb during o_rsp_stb cycle: accepted that cycle, o_wb_stb high next cycle.

Source files
------------

// File: rtl/wb_initiator_pkg.sv
// wb_initiator_pkg: shared state encoding and default sizing for the Wishbone initiator.
package wb_initiator_pkg;

    localparam int DEF_AW        = 30;
    localparam int DEF_TIMEOUT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/wb_timeout.sv
// wb_timeout: counts bus-cycle length and flags the cycle in which it reaches 2^W-1.
module wb_timeout
    import wb_initiator_pkg::*;
#(
    parameter int W = DEF_TIMEOUT_W
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [W-1:0] LAST = {W{1'b1}} - 1'b1;

    logic [W-1:0] r_count;

    // r_count holds the number of completed enabled cycles; the current one makes it +1
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_clear)
            r_count <= '0;
        else if (i_enable)
            r_count <= r_count + 1'b1;
    end

    assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/wb_initiator.sv
// wb_initiator: single-command pipelined Wishbone initiator; WB_INITIATOR_TIMEOUT_EN adds a bus timeout.
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_cmd_stb,
    input  logic          i_cmd_we,
    input  logic [AW-1:0] i_cmd_addr,
    input  logic [31:0]   i_cmd_data,
    input  logic [3:0]    i_cmd_sel,
    output logic          o_cmd_busy,
    output logic          o_rsp_stb,
    output logic          o_rsp_err,
    output logic [31:0]   o_rsp_data,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [31:0]   o_wb_data,
    output logic [3:0]    o_wb_sel,
    input  logic          i_wb_stall,
    input  logic          i_wb_ack,
    input  logic          i_wb_err,
    input  logic [31:0]   i_wb_data
);

    state_t        r_state;
    state_t        w_next;
    logic          w_accept;
    logic          w_done;
    logic          w_timeout;
    logic          w_err;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_data;
    logic [3:0]    r_sel;
    logic          r_rsp_stb;
    logic          r_rsp_err;
    logic [31:0]   r_rsp_data;

`ifdef WB_INITIATOR_TIMEOUT_EN
    wb_timeout #(.W(TIMEOUT_W)) u_timeout (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (w_accept),
        .i_enable  (o_wb_cyc),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // A real ack in the final cycle beats the timeout; err always beats ack
    assign w_err = i_wb_err || (w_timeout && !i_wb_ack);

    // Next state: accept in IDLE, drop stb once not stalled, finish on ack/err/timeout
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = i_cmd_stb;
                w_next   = i_cmd_stb ? ST_REQ : ST_IDLE;
            end
            ST_REQ: begin
                w_done = i_wb_ack || i_wb_err || w_timeout;
                w_next = w_done ? ST_IDLE : (i_wb_stall ? ST_REQ : ST_WAIT);
            end
            ST_WAIT: begin
                w_done = i_wb_ack || i_wb_err || w_timeout;
                w_next = w_done ? ST_IDLE : ST_WAIT;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Request fields are captured once per command and held for the whole bus cycle
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_we   <= i_cmd_we;
            r_addr <= i_cmd_addr;
            r_data <= i_cmd_data;
            r_sel  <= i_cmd_sel;
        end
    end

    // One-cycle response; data is zero for writes and for any error
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rsp_stb  <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            r_rsp_stb <= w_done;
            if (w_done) begin
                r_rsp_err  <= w_err;
                r_rsp_data <= (w_err || r_we) ? 32'd0 : i_wb_data;
            end
        end
    end

    assign o_cmd_busy = (r_state != ST_IDLE);
    assign o_wb_cyc   = (r_state != ST_IDLE);
    assign o_wb_stb   = (r_state == ST_REQ);
    assign o_wb_we    = r_we;
    assign o_wb_addr  = r_addr;
    assign o_wb_data  = r_data;
    assign o_wb_sel   = r_sel;
    assign o_rsp_stb  = r_rsp_stb;
    assign o_rsp_err  = r_rsp_err;
    assign o_rsp_data = r_rsp_data;

endmodule
